// File: rtl/led_cube_uart_rx_poller.sv
// led_cube_uart_rx_poller
// Avalon-MM master that polls a UART status register. When RRDY is set and the
// local byte FIFO has room, it reads rxdata and buffers the low byte. Buffered
// bytes leave on a valid/ready stream, each tagged with a frame-start flag
// marking byte 0 of every FRAME_BYTES-long LED cube frame.
//
// Stream handshake: m_valid is high whenever the FIFO holds a byte. m_data and
// m_frame_start are stable and meaningful while m_valid=1. A byte is consumed
// on every rising clock edge where m_valid=1 and m_ready=1. m_valid never
// depends on m_ready.
module led_cube_uart_rx_poller #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 5,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'('h08),
    parameter logic [ADDR_W-1:0] RXDATA_ADDR = ADDR_W'('h00),
    parameter int                RRDY_BIT    = 7,
    parameter int                FIFO_DEPTH  = 16,
    parameter int                FRAME_BYTES = 64,
    parameter int                POLL_GAP    = 0,
    parameter int                TIMEOUT     = 255
) (
    input  logic                          clock_sink_clk,
    input  logic                          reset_sink_reset,
    input  logic                          enable,
    output logic                          avalon_master_read,
    output logic [ADDR_W-1:0]             avalon_master_address,
    input  logic [DATA_W-1:0]             avalon_master_readdata,
    input  logic                          avalon_master_readdatavalid,
    input  logic                          avalon_master_waitrequest,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_frame_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   byte_count,
    output logic                          timeout_err,
    input  logic                          err_clear,
    output logic [2:0]                    fsm_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int FI_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    typedef enum logic [2:0] {
        S_GAP   = 3'd0,
        S_POLL  = 3'd1,
        S_WSTAT = 3'd2,
        S_RD    = 3'd3,
        S_WDATA = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [15:0]        gap_cnt;
    logic [15:0]        to_cnt;
    logic               gap_done;
    logic               to_last;
    logic               timeout_hit;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [FI_W-1:0]    frame_idx;
    logic [8:0]         mem [FIFO_DEPTH];
    logic               unused_rdata;

    // Only the RRDY bit and the low byte are meaningful; fold the rest away.
    assign unused_rdata = ^avalon_master_readdata;

    assign gap_done  = (gap_cnt >= 16'(POLL_GAP));
    assign to_last   = (to_cnt >= 16'(TIMEOUT - 1));
    assign fifo_full = (level == LVL_W'(FIFO_DEPTH));
    assign pop       = m_valid & m_ready;
    assign fsm_state = state;

    // State register; reset abandons any bus transaction in flight.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset) begin
        if (!reset_sink_reset) state <= S_GAP;
        else                   state <= next_state;
    end

    // Next-state and bus outputs. Requests are held while waitrequest=1, so
    // enable only gates the start of a new poll from S_GAP.
    always_comb begin
        next_state            = state;
        avalon_master_read    = 1'b0;
        avalon_master_address = STATUS_ADDR;
        push                  = 1'b0;
        timeout_hit           = 1'b0;
        case (state)
            S_GAP: begin
                if (gap_done && enable) next_state = S_POLL;
            end
            S_POLL: begin
                avalon_master_read = 1'b1;
                if (!avalon_master_waitrequest) next_state = S_WSTAT;
            end
            S_WSTAT: begin
                if (avalon_master_readdatavalid) begin
                    // A full FIFO leaves the byte waiting inside the UART.
                    if (avalon_master_readdata[RRDY_BIT] && !fifo_full) next_state = S_RD;
                    else                                                next_state = S_GAP;
                end else if (to_last) begin
                    timeout_hit = 1'b1;
                    next_state  = S_GAP;
                end
            end
            S_RD: begin
                avalon_master_read    = 1'b1;
                avalon_master_address = RXDATA_ADDR;
                if (!avalon_master_waitrequest) next_state = S_WDATA;
            end
            S_WDATA: begin
                if (avalon_master_readdatavalid) begin
                    push       = 1'b1;
                    next_state = S_POLL;
                end else if (to_last) begin
                    timeout_hit = 1'b1;
                    next_state  = S_GAP;
                end
            end
            default: next_state = S_GAP;
        endcase
    end

    // Poll gap counter: counts up while in S_GAP and saturates once done.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset) begin
        if (!reset_sink_reset)      gap_cnt <= '0;
        else if (state != S_GAP)    gap_cnt <= '0;
        else if (!gap_done)         gap_cnt <= gap_cnt + 16'd1;
    end

    // Read-response timeout counter: cycles spent waiting for readdatavalid.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset) begin
        if (!reset_sink_reset) begin
            to_cnt <= '0;
        end else if ((state == S_WSTAT || state == S_WDATA) &&
                     !avalon_master_readdatavalid && !to_last) begin
            to_cnt <= to_cnt + 16'd1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset) begin
        if (!reset_sink_reset) timeout_err <= 1'b0;
        else if (timeout_hit)  timeout_err <= 1'b1;
        else if (err_clear)    timeout_err <= 1'b0;
    end

    // Frame position and total byte counter, both advanced per accepted byte.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset) begin
        if (!reset_sink_reset) begin
            frame_idx  <= '0;
            byte_count <= '0;
        end else if (push) begin
            byte_count <= byte_count + 16'd1;
            if (frame_idx == FI_W'(FRAME_BYTES - 1)) frame_idx <= '0;
            else                                     frame_idx <= frame_idx + FI_W'(1);
        end
    end

    // FIFO storage: {frame_start_flag, byte}.
    always_ff @(posedge clock_sink_clk) begin
        if (push) mem[wr_ptr] <= {(frame_idx == '0), avalon_master_readdata[7:0]};
    end

    // FIFO pointers and level; push and pop together leave the level unchanged.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_reset) begin
        if (!reset_sink_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign fifo_level    = level;
    assign m_valid       = (level != '0);
    assign m_data        = mem[rd_ptr][7:0];
    assign m_frame_start = m_valid & mem[rd_ptr][8];

endmodule

// File: tb/tb_led_cube_uart_rx_poller.sv
// Directed testbench for led_cube_uart_rx_poller (default parameters).
// Idle waitrequest is held high so the DUT parks in S_POLL/S_RD until a
// bench task services the request.
module tb_led_cube_uart_rx_poller;

    localparam logic [2:0] ST_GAP   = 3'd0;
    localparam logic [2:0] ST_POLL  = 3'd1;
    localparam logic [2:0] ST_WSTAT = 3'd2;
    localparam logic [2:0] ST_RD    = 3'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        enable;
    logic        rd;
    logic [4:0]  addr_o;
    logic [15:0] rdata;
    logic        rdv;
    logic        wr;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_frame_start;
    logic [4:0]  fifo_level;
    logic [15:0] byte_count;
    logic        timeout_err;
    logic        err_clear;
    logic [2:0]  fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    led_cube_uart_rx_poller dut (
        .clock_sink_clk              (clk),
        .reset_sink_reset            (rst_n),
        .enable                      (enable),
        .avalon_master_read          (rd),
        .avalon_master_address       (addr_o),
        .avalon_master_readdata      (rdata),
        .avalon_master_readdatavalid (rdv),
        .avalon_master_waitrequest   (wr),
        .m_data                      (m_data),
        .m_valid                     (m_valid),
        .m_ready                     (m_ready),
        .m_frame_start               (m_frame_start),
        .fifo_level                  (fifo_level),
        .byte_count                  (byte_count),
        .timeout_err                 (timeout_err),
        .err_clear                   (err_clear),
        .fsm_state                   (fsm_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a read request, check it, stall it ws cycles, accept it.
    task automatic issue(input logic [4:0] addr, input int ws, input string tag);
        int n;
        n = 0;
        while (rd !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_req"}, {31'd0, rd}, 32'd1);
        check({tag, "_addr"}, {27'd0, addr_o}, {27'd0, addr});
        for (int i = 0; i < ws; i++) begin
            wr = 1'b1;
            tick();
            check({tag, "_hold_rd"}, {31'd0, rd}, 32'd1);
            check({tag, "_hold_addr"}, {27'd0, addr_o}, {27'd0, addr});
        end
        wr = 1'b0;
        tick();
        wr = 1'b1;
    endtask

    // Return read data after lat idle wait cycles.
    task automatic respond(input int lat, input logic [15:0] data);
        repeat (lat) tick();
        rdv   = 1'b1;
        rdata = data;
        tick();
        rdv   = 1'b0;
        rdata = 16'h0000;
    endtask

    task automatic serve(input logic [4:0] addr, input int ws, input int lat,
                         input logic [15:0] data, input string tag);
        issue(addr, ws, tag);
        respond(lat, data);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        rdata     = 16'h0000;
        rdv       = 1'b0;
        wr        = 1'b1;
        m_ready   = 1'b0;
        err_clear = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_read",    {31'd0, rd},            32'd0);
        check("rst_addr",    {27'd0, addr_o},        32'h08);
        check("rst_valid",   {31'd0, m_valid},       32'd0);
        check("rst_fstart",  {31'd0, m_frame_start}, 32'd0);
        check("rst_err",     {31'd0, timeout_err},   32'd0);
        check("rst_bcount",  {16'd0, byte_count},    32'd0);
        check("rst_level",   {27'd0, fifo_level},    32'd0);
        check("rst_state",   {29'd0, fsm_state},     {29'd0, ST_GAP});
        rst_n = 1'b1;

        // 1: basic status + rxdata read
        serve(5'h08, 0, 1, 16'h0080, "t1_stat");
        check("t1_state_rd", {29'd0, fsm_state}, {29'd0, ST_RD});
        check("t1_valid_pre", {31'd0, m_valid}, 32'd0);
        serve(5'h00, 0, 1, 16'h00A5, "t1_data");
        check("t1_valid",  {31'd0, m_valid},       32'd1);
        check("t1_data",   {24'd0, m_data},        32'hA5);
        check("t1_fstart", {31'd0, m_frame_start}, 32'd1);
        check("t1_bcount", {16'd0, byte_count},    32'd1);
        check("t1_level",  {27'd0, fifo_level},    32'd1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t1_drained", {31'd0, m_valid}, 32'd0);

        // 2: waitrequest stalls of 3 cycles on both requests
        serve(5'h08, 3, 0, 16'h0080, "t2_stat");
        serve(5'h00, 3, 2, 16'h005A, "t2_data");
        check("t2_bcount", {16'd0, byte_count},    32'd2);
        check("t2_data",   {24'd0, m_data},        32'h5A);
        check("t2_fstart", {31'd0, m_frame_start}, 32'd0);
        repeat (4) tick();
        check("t2_nodup",  {27'd0, fifo_level},    32'd1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t2_drained", {27'd0, fifo_level}, 32'd0);

        // 3: fill FIFO, backpressure on the 17th RRDY, then drain in order
        for (int i = 0; i < 16; i++) begin
            serve(5'h08, 0, 0, 16'h0080, "t3_stat");
            serve(5'h00, 0, 0, 16'(8'h10 + i), "t3_data");
        end
        check("t3_level_full", {27'd0, fifo_level}, 32'd16);
        check("t3_bcount",     {16'd0, byte_count}, 32'd18);
        serve(5'h08, 0, 0, 16'h0080, "t3_full_stat");
        check("t3_no_rd_state", {29'd0, fsm_state}, {29'd0, ST_GAP});
        tick();
        check("t3_repoll_rd",   {31'd0, rd},     32'd1);
        check("t3_repoll_addr", {27'd0, addr_o}, 32'h08);
        check("t3_level_hold",  {27'd0, fifo_level}, 32'd16);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_drain_valid", {31'd0, m_valid}, 32'd1);
            check("t3_drain_data",  {24'd0, m_data},  32'(8'h10 + i));
            tick();
        end
        m_ready = 1'b0;
        check("t3_empty", {31'd0, m_valid}, 32'd0);

        // 5: read timeout, clear, set-beats-clear
        issue(5'h08, 0, "t5_stat");
        repeat (254) tick();
        check("t5_before_to_state", {29'd0, fsm_state},   {29'd0, ST_WSTAT});
        check("t5_before_to_err",   {31'd0, timeout_err}, 32'd0);
        tick();
        check("t5_to_state",  {29'd0, fsm_state},   {29'd0, ST_GAP});
        check("t5_to_err",    {31'd0, timeout_err}, 32'd1);
        check("t5_to_level",  {27'd0, fifo_level},  32'd0);
        check("t5_to_bcount", {16'd0, byte_count},  32'd18);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t5_cleared", {31'd0, timeout_err}, 32'd0);
        issue(5'h08, 0, "t5_stat2");
        repeat (254) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t5_set_wins", {31'd0, timeout_err}, 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t5_cleared2", {31'd0, timeout_err}, 32'd0);

        // 6: reset during S_WDATA with a late readdatavalid
        serve(5'h08, 0, 0, 16'h0080, "t6_stat");
        serve(5'h00, 0, 0, 16'h0033, "t6_data");
        check("t6_level_pre", {27'd0, fifo_level}, 32'd1);
        serve(5'h08, 0, 0, 16'h0080, "t6_stat2");
        issue(5'h00, 0, "t6_rd");
        rst_n = 1'b0;
        rdv   = 1'b1;
        rdata = 16'h0077;
        #1;
        check("t6_rst_read",   {31'd0, rd},          32'd0);
        check("t6_rst_addr",   {27'd0, addr_o},      32'h08);
        check("t6_rst_valid",  {31'd0, m_valid},     32'd0);
        check("t6_rst_level",  {27'd0, fifo_level},  32'd0);
        check("t6_rst_bcount", {16'd0, byte_count},  32'd0);
        check("t6_rst_state",  {29'd0, fsm_state},   {29'd0, ST_GAP});
        tick();
        rst_n = 1'b1;
        tick();
        rdv   = 1'b0;
        rdata = 16'h0000;
        check("t6_post_state",  {29'd0, fsm_state},  {29'd0, ST_POLL});
        check("t6_post_level",  {27'd0, fifo_level}, 32'd0);
        check("t6_post_bcount", {16'd0, byte_count}, 32'd0);
        check("t6_post_valid",  {31'd0, m_valid},    32'd0);

        // 4: 130 bytes streamed; frame start on bytes 0, 64, 128 only
        m_ready = 1'b1;
        for (int k = 0; k < 130; k++) begin
            serve(5'h08, 0, 0, 16'h0080, "t4_stat");
            serve(5'h00, 0, 0, 16'(k & 8'hFF), "t4_data");
            check("t4_valid",  {31'd0, m_valid}, 32'd1);
            check("t4_data",   {24'd0, m_data},  32'(k & 8'hFF));
            check("t4_fstart", {31'd0, m_frame_start}, (k % 64 == 0) ? 32'd1 : 32'd0);
        end
        check("t4_bcount", {16'd0, byte_count}, 32'd130);
        tick();
        check("t4_empty", {27'd0, fifo_level}, 32'd0);
        m_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
